// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states, the buffered
// fetch entry and its flattened width used on the queue ports.
package fetch_pkg;

  localparam int FETCH_ADDR_WIDTH  = 16;
  localparam int FETCH_INSTR_WIDTH = 32;

  localparam logic [FETCH_INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_INSTR_WIDTH-1:0] instr;
    logic [FETCH_ADDR_WIDTH-1:0]  pc;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  function automatic logic [FETCH_ADDR_WIDTH-1:0] pc_plus4(
    input logic [FETCH_ADDR_WIDTH-1:0] pc
  );
    return pc + FETCH_ADDR_WIDTH'(4);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries; clear empties it on the same edge
// and takes priority over push/pop. Push while full is accepted only with a pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] push_data_i,
  input  logic               pop_i,
  input  logic               clear_i,
  output logic [ENTRY_W-1:0] head_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               full_o,
  output logic               empty_o
);

  logic [DEPTH-1:0][ENTRY_W-1:0] slots;
  logic [PTR_W-1:0]              wr_ptr_q;
  logic [PTR_W-1:0]              rd_ptr_q;
  logic [CNT_W-1:0]              count_q;
  logic                          do_push;
  logic                          do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [ENTRY_W-1:0] slot_q;
      always_ff @(posedge clk) begin
        if (do_push && !clear_i && (wr_ptr_q == PTR_W'(gi))) begin
          slot_q <= push_data_i;
        end
      end
      assign slots[gi] = slot_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = slots[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage between the PC and decode: one outstanding imem request, responses
// buffered with their PC, flush drops everything queued or in flight.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = FETCH_ADDR_WIDTH,
  parameter int INSTR_WIDTH = FETCH_INSTR_WIDTH,
  parameter int DEPTH       = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  pc_i,
  output logic                   pc_advance_o,
  input  logic                   flush_i,
  output logic                   imem_req_valid_o,
  input  logic                   imem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]  imem_addr_o,
  input  logic                   imem_rsp_valid_i,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data_i,
  output logic                   id_valid_o,
  input  logic                   id_ready_i,
  output logic [INSTR_WIDTH-1:0] id_instr_o,
  output logic [ADDR_WIDTH-1:0]  id_pc_o,
  output logic [ADDR_WIDTH-1:0]  id_pc_plus4_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t          state_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  logic [CNT_W-1:0]      q_count;
  logic                  q_full;
  logic                  q_empty;
  logic [ENTRY_W-1:0]    head_bits;
  fetch_entry_t          head;
  fetch_entry_t          push_entry;

  logic                  rsp_in_wait;
  logic                  issue_slot;
  logic                  has_room;
  logic                  req_valid;
  logic                  req_fire;
  logic                  push;
  logic                  pop;

  assign rsp_in_wait = (state_q == WAIT) && imem_rsp_valid_i;
  assign issue_slot  = (state_q == IDLE) || rsp_in_wait;

  // In WAIT the response being pushed this cycle already occupies a slot,
  // so a new request needs one more free entry than in IDLE.
  assign has_room  = (state_q == IDLE) ? !q_full : (q_count < CNT_W'(DEPTH - 1));
  assign req_valid = !rst && !flush_i && issue_slot && has_room;
  assign req_fire  = req_valid && imem_req_ready_i;

  assign push = rsp_in_wait && !flush_i;
  assign pop  = id_ready_i && !q_empty;

  always_comb begin
    push_entry       = '0;
    push_entry.instr = imem_rsp_data_i;
    push_entry.pc    = addr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      if (req_fire) addr_q <= pc_i;
      unique case (state_q)
        IDLE: begin
          if (req_fire) state_q <= WAIT;
        end
        WAIT: begin
          if (imem_rsp_valid_i)  state_q <= req_fire ? WAIT : IDLE;
          else if (flush_i)      state_q <= DISCARD;
        end
        DISCARD: begin
          if (imem_rsp_valid_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_data_i(push_entry),
    .pop_i      (pop),
    .clear_i    (flush_i),
    .head_o     (head_bits),
    .count_o    (q_count),
    .full_o     (q_full),
    .empty_o    (q_empty)
  );

  assign head = fetch_entry_t'(head_bits);

  assign imem_req_valid_o = req_valid;
  assign imem_addr_o      = pc_i;
  assign pc_advance_o     = req_fire;

  assign id_valid_o    = !q_empty;
  assign id_instr_o    = q_empty ? '0 : head.instr;
  assign id_pc_o       = q_empty ? '0 : head.pc;
  assign id_pc_plus4_o = q_empty ? '0 : pc_plus4(head.pc);

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: an upstream PC model and a one-slot memory
// model drive the DUT; accepted fetches are queued and matched at decode.
module tb_fetch_stage;

  localparam int AW    = 16;
  localparam int IW    = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] pc_i = '0;
  logic          pc_advance_o;
  logic          flush_i = 1'b0;
  logic          imem_req_valid_o;
  logic          imem_req_ready_i = 1'b1;
  logic [AW-1:0] imem_addr_o;
  logic          imem_rsp_valid_i = 1'b0;
  logic [IW-1:0] imem_rsp_data_i = '0;
  logic          id_valid_o;
  logic          id_ready_i = 1'b1;
  logic [IW-1:0] id_instr_o;
  logic [AW-1:0] id_pc_o;
  logic [AW-1:0] id_pc_plus4_o;

  always #5 clk = ~clk;

  fetch_stage #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .pc_advance_o(pc_advance_o), .flush_i(flush_i),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
    .imem_addr_o(imem_addr_o), .imem_rsp_valid_i(imem_rsp_valid_i),
    .imem_rsp_data_i(imem_rsp_data_i), .id_valid_o(id_valid_o), .id_ready_i(id_ready_i),
    .id_instr_o(id_instr_o), .id_pc_o(id_pc_o), .id_pc_plus4_o(id_pc_plus4_o)
  );

  typedef struct {
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
    int            vis;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_pops = 0;
  logic [AW-1:0] pop_pcs[$];

  logic [AW-1:0] pc_model = '0;
  logic [AW-1:0] flush_target = '0;
  int            mem_lat = 1;
  bit            mb_busy = 0;
  bit            mb_live = 0;
  int            mb_cnt = 0;
  logic [AW-1:0] mb_addr = '0;
  bit            rsp_live = 0;
  bit            mode_wait = 0;
  bit            mode_rsp = 0;

  bit            prev_pending = 0;
  logic [AW-1:0] prev_addr = '0;

  bit            s_req_valid, s_pc_adv, s_id_valid, s_flush, s_fire, s_dropped, s_popped;
  logic [AW-1:0] s_addr;
  logic [AW-1:0] last_pop_pc, last_pop_pc4;

  function automatic logic [IW-1:0] instr_of(input logic [AW-1:0] a);
    return {~a, a} ^ 32'h1357_0013;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: sample and score at negedge, then drive next inputs after posedge.
  task automatic cycle();
    exp_t          e;
    bit            exp_valid;
    logic [AW-1:0] e_pc4;
    @(negedge clk);
    cyc++;
    s_req_valid = imem_req_valid_o;
    s_addr      = imem_addr_o;
    s_pc_adv    = pc_advance_o;
    s_id_valid  = id_valid_o;
    s_flush     = flush_i;
    s_fire      = imem_req_valid_o && imem_req_ready_i;
    s_dropped   = (mb_busy && !mb_live) || (imem_rsp_valid_i && !rsp_live);
    s_popped    = 0;

    check_eq("pc_advance", pc_advance_o, s_fire);
    if (prev_pending && !flush_i) begin
      check_eq("req_hold", imem_req_valid_o, 1);
      check_eq("addr_hold", imem_addr_o, prev_addr);
    end
    if (imem_req_valid_o) check_eq("req_addr", imem_addr_o, pc_model);
    if (flush_i) check_eq("flush_no_req", imem_req_valid_o, 0);

    if (imem_rsp_valid_i && rsp_live && !flush_i && exp_q.size() > 0) begin
      e = exp_q.pop_back();
      e.vis = cyc + 1;
      exp_q.push_back(e);
    end

    exp_valid = (exp_q.size() > 0) && (exp_q[0].vis >= 0) && (cyc >= exp_q[0].vis);
    check_eq("id_valid", id_valid_o, exp_valid);
    if (id_valid_o && id_ready_i && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      e_pc4 = e.pc + 16'd4;
      check_eq("id_instr", id_instr_o, e.instr);
      check_eq("id_pc", id_pc_o, e.pc);
      check_eq("id_pc_plus4", id_pc_plus4_o, e_pc4);
      n_pops++;
      s_popped = 1;
      last_pop_pc  = id_pc_o;
      last_pop_pc4 = id_pc_plus4_o;
      pop_pcs.push_back(id_pc_o);
      $display("[%0d] decode pc=%h instr=%h pc4=%h", cyc, id_pc_o, id_instr_o, id_pc_plus4_o);
    end

    if (flush_i) begin
      exp_q.delete();
      mb_live = 0;
    end
    if (s_fire) begin
      check_eq("one_outstanding", mb_busy, 0);
      mb_busy = 1;
      mb_cnt  = mem_lat;
      mb_addr = imem_addr_o;
      mb_live = 1;
      e.instr = instr_of(pc_model);
      e.pc    = pc_model;
      e.vis   = -1;
      exp_q.push_back(e);
    end

    prev_pending = imem_req_valid_o && !s_fire;
    prev_addr    = imem_addr_o;
    if (flush_i)     pc_model = flush_target;
    else if (s_fire) pc_model = pc_model + 16'd4;

    @(posedge clk);
    #1;
    imem_rsp_valid_i = 1'b0;
    rsp_live = 0;
    if (mb_busy) begin
      if (mb_cnt <= 1) begin
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = instr_of(mb_addr);
        rsp_live = mb_live;
        mb_busy  = 0;
      end else begin
        mb_cnt--;
      end
    end
    flush_i = 1'b0;
    if (mode_wait && mb_busy) begin
      flush_i = 1'b1;
      mode_wait = 0;
    end
    if (mode_rsp && imem_rsp_valid_i && rsp_live) begin
      flush_i = 1'b1;
      mode_rsp = 0;
    end
    pc_i = pc_model;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int            k;
    int            pops_before;
    logic [AW-1:0] stall_addr;

    // Reset held with a stray response and a ready memory.
    rst = 1'b1;
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_req_valid", imem_req_valid_o, 0);
      check_eq("rst_pc_advance", pc_advance_o, 0);
      check_eq("rst_id_valid", id_valid_o, 0);
      check_eq("rst_id_instr", id_instr_o, 0);
      check_eq("rst_id_pc", id_pc_o, 0);
      check_eq("rst_id_pc4", id_pc_plus4_o, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    imem_rsp_valid_i = 1'b0;
    pc_i = pc_model;

    // Streaming from PC 0.
    cycle();
    check_eq("rst_release_req", s_req_valid, 1);
    check_eq("rst_nothing_pushed", s_id_valid, 0);
    for (int i = 0; i < 11; i++) cycle();
    check_eq("stream_pops", (n_pops >= 4), 1);
    if (pop_pcs.size() >= 3) begin
      check_eq("stream_pc0", pop_pcs[0], 16'h0000);
      check_eq("stream_pc1", pop_pcs[1], 16'h0004);
      check_eq("stream_pc2", pop_pcs[2], 16'h0008);
    end

    // Decode backpressure fills the queue.
    id_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    check_eq("bp_id_valid", s_id_valid, 1);
    check_eq("bp_req_valid", s_req_valid, 0);
    check_eq("bp_pc_advance", s_pc_adv, 0);
    check_eq("bp_queued", exp_q.size(), DEPTH);
    id_ready_i = 1'b1;
    pops_before = n_pops;
    for (int i = 0; i < 8; i++) cycle();
    check_eq("bp_drain", ((n_pops - pops_before) >= DEPTH), 1);

    // Memory stall: request must hold steady.
    imem_req_ready_i = 1'b0;
    k = 0;
    cycle();
    while (!s_req_valid && k < 10) begin
      cycle();
      k++;
    end
    check_eq("stall_req_seen", s_req_valid, 1);
    check_eq("stall_adv0", s_pc_adv, 0);
    stall_addr = s_addr;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("stall_req_valid", s_req_valid, 1);
      check_eq("stall_addr", s_addr, stall_addr);
      check_eq("stall_adv", s_pc_adv, 0);
    end
    imem_req_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) cycle();

    // Flush while a request is in flight; its late response must be dropped.
    mem_lat = 3;
    flush_target = 16'h0100;
    mode_wait = 1;
    k = 0;
    cycle();
    while (!s_flush && k < 30) begin
      cycle();
      k++;
    end
    check_eq("flush_wait_seen", s_flush, 1);
    cycle();
    check_eq("flush_clears_valid", s_id_valid, 0);
    k = 0;
    while (k < 30) begin
      if (s_dropped) check_eq("discard_no_req", s_req_valid, 0);
      if (s_fire) break;
      cycle();
      k++;
    end
    check_eq("redirect_fetch", s_fire, 1);
    check_eq("redirect_addr", s_addr, 16'h0100);
    mem_lat = 1;
    for (int i = 0; i < 8; i++) cycle();

    // Flush coinciding with a response, redirect to the top of the address space.
    mem_lat = 2;
    flush_target = 16'hFFFC;
    mode_rsp = 1;
    k = 0;
    cycle();
    while (!s_flush && k < 30) begin
      cycle();
      k++;
    end
    check_eq("flush_rsp_seen", s_flush, 1);
    cycle();
    check_eq("flush_rsp_clears", s_id_valid, 0);
    k = 0;
    while (k < 40 && !(s_popped && last_pop_pc == 16'hFFFC)) begin
      cycle();
      k++;
    end
    check_eq("wrap_seen", (s_popped && last_pop_pc == 16'hFFFC), 1);
    check_eq("wrap_pc4", last_pop_pc4, 16'h0000);
    for (int i = 0; i < 6; i++) cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
